// File: rtl/master_mem_ctrl.sv
// Wavefront read-address sequencer: bank k trails bank k-1 by one cycle.
// Step 0 appears the cycle after the start edge; done pulses one cycle after the last step.
module master_mem_ctrl #(
    parameter int NUM_BANKS = 16,
    parameter int ADDR_W    = 8,
    parameter int DIM_W     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        active,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [DIM_W-1:0]            num_row,
    input  logic [DIM_W-1:0]            num_col,
    output logic [NUM_BANKS*ADDR_W-1:0] out_addr,
    output logic [NUM_BANKS-1:0]        out_en,
    output logic                        done
);

    localparam int STEP_W = DIM_W + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                      r_state, w_state_nxt;
    logic [STEP_W-1:0]           r_step, w_step_nxt;
    logic [ADDR_W-1:0]           r_base, w_base_nxt;
    logic [DIM_W-1:0]            r_row, w_row_nxt;
    logic [DIM_W-1:0]            r_col, w_col_nxt;
    logic [NUM_BANKS-1:0]        r_en, w_en_nxt;
    logic [NUM_BANKS*ADDR_W-1:0] r_addr, w_addr_nxt;
    logic                        r_done, w_done_nxt;

    logic                        w_gen;
    logic [STEP_W-1:0]           w_t;
    logic [STEP_W-1:0]           w_diff;
    logic [STEP_W-1:0]           w_last;
    logic [ADDR_W-1:0]           w_b;
    logic [DIM_W-1:0]            w_r;
    logic [DIM_W-1:0]            w_c;

    assign w_last = {1'b0, r_row} + {1'b0, r_col};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_base  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_en    <= '0;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_base  <= w_base_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_en    <= w_en_nxt;
            r_addr  <= w_addr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_base_nxt  = r_base;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_done_nxt  = 1'b0;
        w_en_nxt    = '0;
        w_addr_nxt  = '0;
        w_gen       = 1'b0;
        w_t         = r_step + 1'b1;
        w_b         = r_base;
        w_r         = r_row;
        w_c         = r_col;
        w_diff      = '0;

        case (r_state)
            IDLE: begin
                // Step 0 is built straight from the inputs so it is visible one cycle after start.
                if (active) begin
                    w_state_nxt = RUN;
                    w_step_nxt  = '0;
                    w_base_nxt  = base_addr;
                    w_row_nxt   = num_row;
                    w_col_nxt   = num_col;
                    w_gen       = 1'b1;
                    w_t         = '0;
                    w_b         = base_addr;
                    w_r         = num_row;
                    w_c         = num_col;
                end
            end
            RUN: begin
                if (r_step == w_last) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_step_nxt = r_step + 1'b1;
                    w_gen      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_gen) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                w_diff = w_t - STEP_W'(k);
                if ((STEP_W'(k) <= w_t) && (DIM_W'(k) <= w_c) && (w_diff <= {1'b0, w_r})) begin
                    w_en_nxt[k]                     = 1'b1;
                    w_addr_nxt[k*ADDR_W +: ADDR_W] = w_b + ADDR_W'(w_diff);
                end
            end
        end
    end

    assign out_addr = r_addr;
    assign out_en   = r_en;
    assign done     = r_done;

endmodule

// File: tb/tb_master_mem_ctrl.sv
// Scoreboarded bench for master_mem_ctrl: expected per-cycle outputs queued by tag, popped at negedge.
module tb_master_mem_ctrl;

    logic         clk;
    logic         reset;
    logic         active;
    logic [7:0]   base_addr;
    logic [3:0]   num_row;
    logic [3:0]   num_col;
    logic [127:0] out_addr;
    logic [15:0]  out_en;
    logic         done;

    master_mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .base_addr (base_addr),
        .num_row   (num_row),
        .num_col   (num_col),
        .out_addr  (out_addr),
        .out_en    (out_en),
        .done      (done)
    );

    typedef struct packed {
        logic [15:0]  en;
        logic [127:0] addr;
        logic         done;
    } exp_t;

    typedef struct {
        int    tag;
        exp_t  e;
        string nm;
    } rec_t;

    rec_t q[$];
    rec_t mon_r;
    int   cyc_cnt  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= cyc_cnt) begin
            mon_r = q.pop_front();
            n_checks++;
            if (out_en !== mon_r.e.en || out_addr !== mon_r.e.addr || done !== mon_r.e.done) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got en=%h addr=%h done=%b, expected en=%h addr=%h done=%b",
                         mon_r.nm, cyc_cnt, out_en, out_addr, done,
                         mon_r.e.en, mon_r.e.addr, mon_r.e.done);
            end
        end
    end

    // Expected outputs for step t straight from the wavefront definition.
    function automatic exp_t step_exp(int t, int row, int col, logic [7:0] base);
        exp_t e;
        e = '0;
        for (int k = 0; k < 16; k++) begin
            int d;
            d = t - k;
            if (k <= col && d >= 0 && d <= row) begin
                e.en[k]          = 1'b1;
                e.addr[k*8 +: 8] = base + 8'(d);
            end
        end
        return e;
    endfunction

    function automatic exp_t done_exp();
        exp_t e;
        e      = '0;
        e.done = 1'b1;
        return e;
    endfunction

    task automatic cyc(input logic rst, input logic act, input logic [7:0] b,
                       input logic [3:0] r, input logic [3:0] c,
                       input exp_t e, input string nm);
        rec_t rr;
        reset     = rst;
        active    = act;
        base_addr = b;
        num_row   = r;
        num_col   = c;
        rr.tag    = cyc_cnt + 1;
        rr.e      = e;
        rr.nm     = nm;
        q.push_back(rr);
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_plain(input logic [7:0] b, input logic [3:0] r,
                               input logic [3:0] c, input string nm);
        int len;
        len = int'(r) + int'(c) + 1;
        cyc(1'b0, 1'b1, b, r, c, step_exp(0, int'(r), int'(c), b), {nm, "_step"});
        for (int t = 1; t < len; t++)
            cyc(1'b0, 1'b0, b, r, c, step_exp(t, int'(r), int'(c), b), {nm, "_step"});
        cyc(1'b0, 1'b0, b, r, c, done_exp(), {nm, "_done"});
        cyc(1'b0, 1'b0, b, r, c, exp_t'(0), {nm, "_after"});
    endtask

    initial begin
        exp_t e;
        reset     = 1'b1;
        active    = 1'b0;
        base_addr = 8'h00;
        num_row   = 4'd0;
        num_col   = 4'd0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 4'd0, exp_t'(0), "reset");
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, exp_t'(0), "idle_after_reset");

        sweep_plain(8'h00, 4'd3, 4'd7, "basic");

        // Address wrap on a single lane, hand-written values.
        e = '0; e.en = 16'h0001; e.addr[7:0] = 8'hFE;
        cyc(1'b0, 1'b1, 8'hFE, 4'd3, 4'd0, e, "wrap_fe");
        e.addr[7:0] = 8'hFF;
        cyc(1'b0, 1'b0, 8'hFE, 4'd3, 4'd0, e, "wrap_ff");
        e.addr[7:0] = 8'h00;
        cyc(1'b0, 1'b0, 8'hFE, 4'd3, 4'd0, e, "wrap_00");
        e.addr[7:0] = 8'h01;
        cyc(1'b0, 1'b0, 8'hFE, 4'd3, 4'd0, e, "wrap_01");
        cyc(1'b0, 1'b0, 8'hFE, 4'd3, 4'd0, done_exp(), "wrap_done");
        cyc(1'b0, 1'b0, 8'hFE, 4'd3, 4'd0, exp_t'(0), "wrap_after");

        // Inputs disturbed mid-sweep and active high at the completion edge: all ignored.
        cyc(1'b0, 1'b1, 8'h00, 4'd3, 4'd7, step_exp(0, 3, 7, 8'h00), "ignore_step");
        for (int t = 1; t < 11; t++)
            cyc(1'b0, (t == 4 || t == 5), (t >= 4) ? 8'h55 : 8'h00, (t >= 4) ? 4'd0 : 4'd3,
                4'd7, step_exp(t, 3, 7, 8'h00), "ignore_step");
        cyc(1'b0, 1'b1, 8'h55, 4'd0, 4'd7, done_exp(), "ignore_done");
        cyc(1'b0, 1'b0, 8'h55, 4'd0, 4'd7, exp_t'(0), "ignore_after");

        // Reset aborts a sweep; no done afterwards, then a fresh start.
        for (int t = 0; t < 6; t++)
            cyc(1'b0, (t == 0), 8'h20, 4'd3, 4'd7, step_exp(t, 3, 7, 8'h20), "abort_step");
        cyc(1'b1, 1'b0, 8'h20, 4'd3, 4'd7, exp_t'(0), "abort_reset");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 8'h20, 4'd3, 4'd7, exp_t'(0), "abort_no_done");

        // Active held high: back-to-back sweeps separated by one done cycle.
        for (int t = 0; t < 4; t++)
            cyc(1'b0, 1'b1, 8'h40, 4'd1, 4'd2, step_exp(t, 1, 2, 8'h40), "b2b_first");
        cyc(1'b0, 1'b1, 8'h40, 4'd1, 4'd2, done_exp(), "b2b_done1");
        cyc(1'b0, 1'b1, 8'h40, 4'd1, 4'd2, step_exp(0, 1, 2, 8'h40), "b2b_restart");
        for (int t = 1; t < 4; t++)
            cyc(1'b0, 1'b0, 8'h40, 4'd1, 4'd2, step_exp(t, 1, 2, 8'h40), "b2b_second");
        cyc(1'b0, 1'b0, 8'h40, 4'd1, 4'd2, done_exp(), "b2b_done2");
        cyc(1'b0, 1'b0, 8'h40, 4'd1, 4'd2, exp_t'(0), "b2b_after");

        // Degenerate 1x1 matrix.
        e = '0; e.en = 16'h0001; e.addr[7:0] = 8'h99;
        cyc(1'b0, 1'b1, 8'h99, 4'd0, 4'd0, e, "deg_step0");
        cyc(1'b0, 1'b0, 8'h99, 4'd0, 4'd0, done_exp(), "deg_done");
        cyc(1'b0, 1'b0, 8'h99, 4'd0, 4'd0, exp_t'(0), "deg_after");

        sweep_plain(8'h10, 4'd15, 4'd15, "full");

        for (int i = 0; i < 2; i++)
            cyc(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, exp_t'(0), "idle_tail");

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/master_mem_ctrl.md
Name:
master_mem_ctrl

Overview:
Read-address sequencer for the 16 weight/activation memory banks that feed the 16-lane systolic array. One `active` pulse starts a matrix read. The block then emits a diagonally skewed (wavefront) stream of per-bank read addresses and enables, so that bank k lags bank k-1 by one cycle. `done` pulses once when the sweep completes.

Parameters:
NUM_BANKS, 16, number of memory banks/lanes; also the maximum matrix dimension.
ADDR_W, 8, per-bank address width.
DIM_W, 4, width of the num_row/num_col fields (log2 NUM_BANKS).

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
active  in  1  start strobe; sampled only when idle.
base_addr  in  8  address of matrix row 0 in every bank.
num_row  in  4  number of rows minus one (rows = num_row+1).
num_col  in  4  number of columns minus one (lanes used = num_col+1).
out_addr  out  128  16 packed lane addresses; lane k at bits [8k+7:8k].
out_en  out  16  per-lane read enable; bit k = bank k.
done  out  1  one-cycle completion pulse.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state IDLE, step counter 0, out_en=0, out_addr=0, done=0. Latched base/row/col cleared to 0.
- Reset has priority over everything and aborts a sweep in progress. No done pulse is produced for the aborted sweep.
- States are IDLE and RUN. All outputs are registered.
- IDLE: on an edge with active=1:
  - latch base_addr, num_row, num_col;
  - set step t=0 and enter RUN.
  - Inputs are not used again until the next start.
- Let L = num_row + num_col + 1 (range 1..31).
- Step t occupies the cycle following start edge E0+t, for t = 0..L-1.
- In step t, lane k is enabled iff k <= num_col and 0 <= t-k <= num_row.
  - Enabled lane: out_en[k]=1, lane address = base_addr + (t-k), modulo 256 (wrap-around, no error).
  - Disabled lane: out_en[k]=0, lane address = 0.
- Edge E0+L (the edge after the last step):
  - out_en=0, out_addr=0, done=1, state returns to IDLE.
  - The following edge clears done, unless a new sweep starts.
- active while in RUN (including at edge E0+L) is ignored. It is not queued.
- active=1 on the edge where done is high is a legal new start. Step 0 of the new sweep is then visible in the next cycle, and done drops.
- active held high continuously restarts a sweep on each IDLE edge. This gives back-to-back sweeps with one done cycle between them.
- Degenerate case num_row=0, num_col=0: L=1. Exactly one cycle with out_en=0x0001, lane0=base_addr; then done.
- Full case num_row=15, num_col=15: L=31. Lane 15 is last enabled at step 30.

Test Plan:
- Reset held 2 cycles, then released with active=0 -> out_en=0x0000, out_addr=0, done=0 indefinitely.
- base=0x00, num_row=3, num_col=7, one-cycle active pulse:
  - step0: out_en=0x0001, lane0=0;
  - step3: out_en=0x000F, lanes0..3 = 3,2,1,0;
  - step7: out_en=0x00F0, lanes4..7 = 3,2,1,0;
  - step10: out_en=0x0080, lane7=3;
  - next cycle: done=1, out_en=0; the cycle after: done=0.
- base=0xFE, num_row=3, num_col=0 -> lane0 addresses 0xFE, 0xFF, 0x00, 0x01 over 4 cycles (wrap), then done.
- Sweep as in the second scenario, with active re-pulsed at step 4 and base_addr changed mid-sweep -> sequence unchanged, single done after step 10.
- reset asserted at step 5 -> next cycle all outputs 0, no done. A fresh active then starts again from step 0.
- num_row=15, num_col=15, base=0x10:
  - step15: out_en=0xFFFF, lane k = 0x10+15-k;
  - step30: out_en=0x8000, lane15=0x1F;
  - done follows.
